// File: rtl/tcam_cfg_bus_arbiter.sv
// Round-robin owner of the TCAM config register bus: one requester holds it for a whole frame, then a guard gap.
// Forwarded words appear 1 cycle after the granted requester drives them; the grant start waits while the TCAM is busy.
module tcam_cfg_bus_arbiter #(
    parameter int NUM_REQ            = 4,
    parameter int REQ_ID_WIDTH       = 2,
    parameter int REG_ADDR_BUS_WIDTH = 8,
    parameter int REG_DATA_BUS_WIDTH = 16,
    parameter int GAP_CYCLES         = 4,
    parameter int TIMEOUT_CYCLES     = 255
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NUM_REQ-1:0]                       i_req,
    input  logic [NUM_REQ-1:0]                       i_req_we,
    input  logic [NUM_REQ*REG_ADDR_BUS_WIDTH-1:0]    i_req_we_addr,
    input  logic [NUM_REQ*REG_DATA_BUS_WIDTH-1:0]    i_req_we_din,
    input  logic [NUM_REQ-1:0]                       i_req_we_din_v,
    input  logic [NUM_REQ-1:0]                       i_req_last,
    input  logic                                     i_tcam_busy,
    output logic [NUM_REQ-1:0]                       o_gnt,
    output logic                                     o_reg_bus_we,
    output logic [REG_ADDR_BUS_WIDTH-1:0]            o_reg_bus_we_addr,
    output logic [REG_DATA_BUS_WIDTH-1:0]            o_reg_bus_we_din,
    output logic                                     o_reg_bus_we_din_v,
    output logic                                     o_arb_busy,
    output logic                                     o_timeout,
    output logic [REQ_ID_WIDTH-1:0]                  o_timeout_id
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RDY = 2'd1,
        XFER     = 2'd2,
        GAP      = 2'd3
    } state_t;

    state_t                          state;
    state_t                          state_nxt;
    logic [REQ_ID_WIDTH-1:0]         gnt_id;
    logic [REQ_ID_WIDTH-1:0]         rr_ptr;
    logic [REQ_ID_WIDTH-1:0]         sel_id;
    logic [REQ_ID_WIDTH-1:0]         rr_nxt;
    logic [7:0]                      idle_cnt;
    logic [GAP_W-1:0]                gap_cnt;

    logic                            g_req;
    logic                            g_we;
    logic                            g_dv;
    logic                            g_last;
    logic [REG_ADDR_BUS_WIDTH-1:0]   g_addr;
    logic [REG_DATA_BUS_WIDTH-1:0]   g_din;

    logic                            word_vld;
    logic                            fwd;
    logic                            end_last;
    logic                            to_hit;
    logic                            xfer_end;

    // Only the owner's lanes are ever looked at; everyone else is muted here.
    always_comb begin
        g_req  = 1'b0;
        g_we   = 1'b0;
        g_dv   = 1'b0;
        g_last = 1'b0;
        g_addr = '0;
        g_din  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_id == REQ_ID_WIDTH'(k)) begin
                g_req  = i_req[k];
                g_we   = i_req_we[k];
                g_dv   = i_req_we_din_v[k];
                g_last = i_req_last[k];
                g_addr = i_req_we_addr[k*REG_ADDR_BUS_WIDTH +: REG_ADDR_BUS_WIDTH];
                g_din  = i_req_we_din[k*REG_DATA_BUS_WIDTH +: REG_DATA_BUS_WIDTH];
            end
        end
    end

    // First pending request at or after rr_ptr, wrapping.
    always_comb begin
        int  idx;
        logic found;
        idx    = 0;
        found  = 1'b0;
        sel_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && i_req[idx]) begin
                found  = 1'b1;
                sel_id = REQ_ID_WIDTH'(idx);
            end
        end
    end

    assign word_vld = g_we & g_dv;
    assign fwd      = (state == XFER) & g_req & word_vld;
    assign end_last = fwd & g_last;
    // A valid word clears the idle count, so last always beats timeout.
    assign to_hit   = (state == XFER) & g_req & ~word_vld & (idle_cnt == TO_LAST);
    assign xfer_end = (state == XFER) & (~g_req | end_last | to_hit);
    assign rr_nxt   = (gnt_id == REQ_ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (|i_req)       state_nxt = WAIT_RDY;
            WAIT_RDY: if (!i_tcam_busy) state_nxt = XFER;
            XFER:     if (xfer_end)     state_nxt = GAP;
            GAP:      if (gap_cnt == GAP_LAST) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_gnt      = '0;
        o_arb_busy = (state != IDLE);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (state == XFER && gnt_id == REQ_ID_WIDTH'(k)) begin
                o_gnt[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_id             <= '0;
            rr_ptr             <= '0;
            idle_cnt           <= '0;
            gap_cnt            <= '0;
            o_reg_bus_we       <= 1'b0;
            o_reg_bus_we_din_v <= 1'b0;
            o_reg_bus_we_addr  <= '0;
            o_reg_bus_we_din   <= '0;
            o_timeout          <= 1'b0;
            o_timeout_id       <= '0;
        end else begin
            if (state == IDLE && |i_req) begin
                gnt_id <= sel_id;
            end

            if (xfer_end) begin
                rr_ptr <= rr_nxt;
            end

            if (state == XFER && !word_vld) begin
                idle_cnt <= idle_cnt + 8'd1;
            end else begin
                idle_cnt <= '0;
            end

            if (state == GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end

            o_reg_bus_we       <= fwd;
            o_reg_bus_we_din_v <= fwd;
            if (fwd) begin
                o_reg_bus_we_addr <= g_addr;
                o_reg_bus_we_din  <= g_din;
            end

            o_timeout <= to_hit;
            if (to_hit) begin
                o_timeout_id <= gnt_id;
            end
        end
    end

endmodule

// File: tb/tb_tcam_cfg_bus_arbiter.sv
// Directed bench for tcam_cfg_bus_arbiter: a cycle table plus hand sequences for frames, round robin, timeout and reset.
module tb_tcam_cfg_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [63:0] din;
    logic [3:0]  dv;
    logic [3:0]  last;
    logic        busy;
    logic [3:0]  gnt;
    logic        bus_we;
    logic [7:0]  bus_addr;
    logic [15:0] bus_din;
    logic        bus_dv;
    logic        arb_busy;
    logic        tmo;
    logic [1:0]  tmo_id;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tcam_cfg_bus_arbiter dut (
        .clk                (clk),
        .rst                (rst),
        .i_req              (req),
        .i_req_we           (we),
        .i_req_we_addr      (addr),
        .i_req_we_din       (din),
        .i_req_we_din_v     (dv),
        .i_req_last         (last),
        .i_tcam_busy        (busy),
        .o_gnt              (gnt),
        .o_reg_bus_we       (bus_we),
        .o_reg_bus_we_addr  (bus_addr),
        .o_reg_bus_we_din   (bus_din),
        .o_reg_bus_we_din_v (bus_dv),
        .o_arb_busy         (arb_busy),
        .o_timeout          (tmo),
        .o_timeout_id       (tmo_id)
    );

    typedef struct packed {
        logic [3:0]  req;
        logic [3:0]  we;
        logic [3:0]  dv;
        logic [3:0]  last;
        logic        busy;
        logic [15:0] din;
        logic [3:0]  e_gnt;
        logic        e_we;
        logic [15:0] e_din;
        logic        e_busy;
    } vec_t;

    vec_t tbl [22];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic put(input int k, input logic [7:0] a, input logic [15:0] d, input logic l);
        we[k]   = 1'b1;
        dv[k]   = 1'b1;
        last[k] = l;
        addr[k*8 +: 8]   = a;
        din[k*16 +: 16]  = d;
    endtask

    task automatic clr(input int k);
        we[k]   = 1'b0;
        dv[k]   = 1'b0;
        last[k] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0; we = '0; dv = '0; last = '0; busy = 1'b0;
        addr = '0; din = '0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic wait_gnt(input string nm, input logic [3:0] exp);
        int n;
        n = 0;
        while (gnt === 4'b0000 && n < 300) begin
            cyc();
            n++;
        end
        chk(nm, gnt, exp);
    endtask

    function automatic vec_t mk(input logic [3:0] r, input logic [3:0] w, input logic [3:0] l,
                                input logic b, input logic [15:0] d, input logic [3:0] eg,
                                input logic ew, input logic [15:0] ed, input logic eb);
        vec_t v;
        v.req = r; v.we = w; v.dv = w; v.last = l; v.busy = b; v.din = d;
        v.e_gnt = eg; v.e_we = ew; v.e_din = ed; v.e_busy = eb;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int early;
        int ord [5];

        // Requester 1 waits out 10 busy cycles, requester 3's words are dropped while 1 owns the bus,
        // then 3 is granted and aborts by dropping its request.
        for (int i = 0; i < 10; i++) tbl[i] = mk(4'b0010, 4'b0000, 4'b0000, 1'b1, 16'h0000, 4'b0000, 1'b0, 16'h0, 1'b1);
        tbl[10] = mk(4'b0010, 4'b0000, 4'b0000, 1'b0, 16'h0000, 4'b0010, 1'b0, 16'h0,    1'b1);
        tbl[11] = mk(4'b1010, 4'b1000, 4'b0000, 1'b0, 16'h2000, 4'b0010, 1'b0, 16'h0,    1'b1);
        tbl[12] = mk(4'b1010, 4'b0010, 4'b0000, 1'b0, 16'h2000, 4'b0010, 1'b1, 16'h2001, 1'b1);
        tbl[13] = mk(4'b1010, 4'b1000, 4'b1000, 1'b0, 16'h2100, 4'b0010, 1'b0, 16'h0,    1'b1);
        tbl[14] = mk(4'b1010, 4'b0010, 4'b0010, 1'b0, 16'h2200, 4'b0000, 1'b1, 16'h2201, 1'b1);
        tbl[15] = mk(4'b1000, 4'b0000, 4'b0000, 1'b0, 16'h0000, 4'b0000, 1'b0, 16'h0,    1'b1);
        tbl[16] = mk(4'b1000, 4'b0000, 4'b0000, 1'b0, 16'h0000, 4'b0000, 1'b0, 16'h0,    1'b1);
        tbl[17] = mk(4'b1000, 4'b0000, 4'b0000, 1'b0, 16'h0000, 4'b0000, 1'b0, 16'h0,    1'b1);
        tbl[18] = mk(4'b1000, 4'b0000, 4'b0000, 1'b0, 16'h0000, 4'b0000, 1'b0, 16'h0,    1'b0);
        tbl[19] = mk(4'b1000, 4'b0000, 4'b0000, 1'b0, 16'h0000, 4'b0000, 1'b0, 16'h0,    1'b1);
        tbl[20] = mk(4'b1000, 4'b0000, 4'b0000, 1'b0, 16'h0000, 4'b1000, 1'b0, 16'h0,    1'b1);
        tbl[21] = mk(4'b0000, 4'b1000, 4'b0000, 1'b0, 16'h2300, 4'b0000, 1'b0, 16'h0,    1'b1);

        do_reset();
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_we", {bus_we, bus_dv}, 2'b00);
        chk("rst_addr_din", {bus_addr, bus_din}, 24'h0);
        chk("rst_busy_to", {arb_busy, tmo, tmo_id}, 4'b0000);

        // 21-word frame from requester 0.
        req[0] = 1'b1;
        cyc();
        chk("f21_gnt_c1", gnt, 4'b0000);
        cyc();
        chk("f21_gnt_c2", gnt, 4'b0001);
        for (int i = 0; i < 21; i++) begin
            put(0, 8'h00, 16'h1000 + 16'(i), i == 20);
            cyc();
            chk("f21_we", {bus_we, bus_dv}, 2'b11);
            chk("f21_word", {bus_addr, bus_din}, {8'h00, 16'h1000 + 16'(i)});
            chk("f21_gnt", gnt, (i == 20) ? 4'b0000 : 4'b0001);
        end
        clr(0);
        req[0] = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            cyc();
            chk("f21_gap_busy", arb_busy, (j < 4) ? 1'b1 : 1'b0);
            chk("f21_gap_we", bus_we, 1'b0);
        end

        do_reset();
        for (int i = 0; i < 22; i++) begin
            req = tbl[i].req; we = tbl[i].we; dv = tbl[i].dv; last = tbl[i].last; busy = tbl[i].busy;
            for (int k = 0; k < 4; k++) begin
                din[k*16 +: 16] = tbl[i].din + 16'(k);
                addr[k*8 +: 8]  = 8'h10 + 8'(k);
            end
            cyc();
            chk($sformatf("tbl%0d_gnt", i), gnt, tbl[i].e_gnt);
            chk($sformatf("tbl%0d_we", i), {bus_we, bus_dv}, {tbl[i].e_we, tbl[i].e_we});
            chk($sformatf("tbl%0d_busy", i), arb_busy, tbl[i].e_busy);
            chk($sformatf("tbl%0d_to", i), tmo, 1'b0);
            if (tbl[i].e_we) chk($sformatf("tbl%0d_din", i), bus_din, tbl[i].e_din);
        end

        // Round robin across all four, requester 0 re-requests during requester 2's frame.
        do_reset();
        ord[0] = 0; ord[1] = 1; ord[2] = 2; ord[3] = 3; ord[4] = 0;
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_gnt($sformatf("rr_order%0d", n), 4'(1 << ord[n]));
            if (n == 2) req[0] = 1'b1;
            for (int w = 0; w < 3; w++) begin
                put(ord[n], 8'h20 + 8'(ord[n]), 16'h4000 + 16'(ord[n] * 16 + w), w == 2);
                cyc();
                chk($sformatf("rr_word%0d_%0d", n, w), {bus_we, bus_addr, bus_din},
                    {1'b1, 8'h20 + 8'(ord[n]), 16'h4000 + 16'(ord[n] * 16 + w)});
            end
            clr(ord[n]);
            req[ord[n]] = 1'b0;
        end

        // Requester 2 stalls after two words and is timed out; requester 3 follows.
        do_reset();
        req = 4'b1100;
        wait_gnt("to_gnt2", 4'b0100);
        for (int w = 0; w < 2; w++) begin
            put(2, 8'h30, 16'h5000 + 16'(w), 1'b0);
            cyc();
            chk("to_word", {bus_we, bus_din}, {1'b1, 16'h5000 + 16'(w)});
        end
        clr(2);
        early = 0;
        for (int c = 1; c <= 254; c++) begin
            cyc();
            if (tmo !== 1'b0 || gnt !== 4'b0100 || bus_we !== 1'b0) early++;
        end
        chk("to_early", early, 0);
        cyc();
        chk("to_pulse", {tmo, tmo_id}, {1'b1, 2'd2});
        chk("to_gnt_drop", gnt, 4'b0000);
        req[2] = 1'b0;
        cyc();
        chk("to_one_pulse", {tmo, tmo_id}, {1'b0, 2'd2});
        wait_gnt("to_next_gnt3", 4'b1000);

        // Last word landing on the would-be timeout cycle is forwarded and no timeout is reported.
        early = 0;
        for (int c = 1; c <= 254; c++) begin
            cyc();
            if (tmo !== 1'b0 || gnt !== 4'b1000) early++;
        end
        chk("lw_early", early, 0);
        put(3, 8'h33, 16'h6abc, 1'b1);
        cyc();
        chk("lw_word", {bus_we, bus_din, gnt}, {1'b1, 16'h6abc, 4'b0000});
        chk("lw_no_to", tmo, 1'b0);
        clr(3);
        req[3] = 1'b0;
        cyc();
        chk("lw_no_to2", {tmo, tmo_id}, {1'b0, 2'd2});

        // Reset on the 5th word of requester 1's frame; rr pointer must restart at 0.
        req = 4'b0010;
        wait_gnt("mr_gnt1", 4'b0010);
        for (int w = 0; w < 4; w++) begin
            put(1, 8'h40, 16'h7000 + 16'(w), 1'b0);
            cyc();
            chk("mr_word", {bus_we, bus_din}, {1'b1, 16'h7000 + 16'(w)});
        end
        put(1, 8'h40, 16'h7004, 1'b0);
        rst = 1'b1;
        cyc();
        chk("mr_gnt", gnt, 4'b0000);
        chk("mr_bus", {bus_we, bus_dv, bus_addr, bus_din}, 26'h0);
        chk("mr_state", {arb_busy, tmo, tmo_id}, 4'b0000);
        rst = 1'b0;
        clr(1);
        req = 4'b1001;
        wait_gnt("mr_rr_from0", 4'b0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tcam_cfg_bus_arbiter.md
Name: tcam_cfg_bus_arbiter

Overview:
Shares the single TCAM configuration register bus between NUM_REQ independent table-write sources, for example the host CPU path and per-port learning/test writers.
- Grants the bus to one requester for a whole table transaction: a write/modify/delete frame of 16-bit words.
- Uses round-robin fairness.
- Holds off the start of a grant while the TCAM reports busy.
- Inserts a guard gap between transactions.
- Aborts a stalled owner by timeout.
- Sits between the requesters and the TCAM register interface.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
REQ_ID_WIDTH, 2, width of requester index; must satisfy 2**REQ_ID_WIDTH >= NUM_REQ
REG_ADDR_BUS_WIDTH, 8, register address width
REG_DATA_BUS_WIDTH, 16, register data width
GAP_CYCLES, 4, idle cycles forced after each transaction (>=1)
TIMEOUT_CYCLES, 255, max consecutive XFER cycles without a valid word before abort (8-bit counter)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
i_req  input  NUM_REQ  per-requester transaction request (level, held until last word sent)
i_req_we  input  NUM_REQ  per-requester register write enable
i_req_we_addr  input  NUM_REQ*REG_ADDR_BUS_WIDTH  packed addresses, requester k at [k*W +: W]
i_req_we_din  input  NUM_REQ*REG_DATA_BUS_WIDTH  packed write data
i_req_we_din_v  input  NUM_REQ  per-requester data valid
i_req_last  input  NUM_REQ  marks final word of the transaction (qualified by we&din_v)
i_tcam_busy  input  1  TCAM busy
o_gnt  output  NUM_REQ  one-hot grant, asserted only in XFER
o_reg_bus_we  output  1  to TCAM
o_reg_bus_we_addr  output  REG_ADDR_BUS_WIDTH  to TCAM
o_reg_bus_we_din  output  REG_DATA_BUS_WIDTH  to TCAM
o_reg_bus_we_din_v  output  1  to TCAM
o_arb_busy  output  1  high whenever state != IDLE
o_timeout  output  1  one-cycle pulse on timeout abort
o_timeout_id  output  REQ_ID_WIDTH  index of aborted requester; holds until next timeout

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous, active-high.
- Reset values: all outputs 0, state IDLE, rr pointer 0, counters 0. Reset mid-transaction sets all outputs to 0 at the next edge. Any partial frame is discarded; the TCAM is not notified.
- State IDLE:
  - If any i_req bit is set, select the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - Latch that index as gnt_id and go to WAIT_RDY.
- State WAIT_RDY: when i_tcam_busy==0, go to XFER. o_gnt[gnt_id] rises on XFER entry.
- State XFER:
  - The granted requester's we/addr/din/din_v are registered onto o_reg_bus_*, giving exactly 1 cycle of latency.
  - Non-granted requesters' we/din_v are ignored: dropped, never forwarded.
  - i_tcam_busy is not re-checked during XFER; the TCAM buffers an entire frame.
  - Normal end: the cycle sampling we&din_v&last of gnt_id forwards that word and moves to GAP. o_gnt drops on the same edge.
  - Abort by requester: i_req[gnt_id] falls before last. Move to GAP and forward nothing further.
  - Abort by timeout: the idle counter increments every XFER cycle without we&din_v from gnt_id and clears on a valid word. When it reaches TIMEOUT_CYCLES, pulse o_timeout, set o_timeout_id=gnt_id, and go to GAP.
  - If last and timeout coincide, last wins: the word is forwarded and no timeout is reported.
- State GAP:
  - On entry, rr_ptr = (gnt_id+1) mod NUM_REQ.
  - Count GAP_CYCLES cycles, then return to IDLE.
  - Requests raised during GAP wait.
- o_reg_bus_we and o_reg_bus_we_din_v are 0 in every cycle that is not forwarding a word.
- Minimum spacing between the last word of one transaction and the first granted cycle of the next is GAP_CYCLES+2 cycles.

Test Plan:
- Single requester 0 sends a 21-word frame (addr 0x00, data 0x1000..0x1014, last on word 21), i_tcam_busy=0 -> grant 2 cycles after i_req; 21 outputs in order, each 1 cycle after input; o_gnt drops after word 21; o_arb_busy low 4 cycles later.
- All 4 requesters raise i_req together with 3-word frames -> service order 0,1,2,3. Then requester 0 re-requests while 2 is active -> order continues 3,0 with no starvation.
- i_tcam_busy held high 10 cycles when requester 1 requests -> o_gnt stays 0 for the 10 cycles and rises on the first cycle after busy drops.
- Requester 2 granted, sends 2 words, then goes silent -> after 255 idle XFER cycles o_timeout pulses once with o_timeout_id=2; requester 3 is granted next.
- Requester 3 writes while requester 1 holds the grant -> no word from requester 3 appears on o_reg_bus_*.
- rst asserted on the 5th word of a frame -> next cycle all outputs 0 and state IDLE. The next request is arbitrated from requester 0.
